// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS store path: store size encodings, the
// store FSM state type, the default lane ordering, and the alignment check.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  // 1 = MIPS big-endian lane numbering, 0 = little-endian.
  localparam bit BIG_ENDIAN_DEFAULT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // High when a store of this size at this byte offset must be rejected.
  function automatic logic store_faults(input logic [1:0] size,
                                        input logic [1:0] addr_lo);
    logic f;
    case (size)
      SZ_BYTE: f = 1'b0;
      SZ_HALF: f = addr_lo[0];
      SZ_WORD: f = |addr_lo;
      default: f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane insertion for sub-word stores.
//   old_word : word previously read from memory
//   wdata    : register value; only the low 8/16/32 bits are used
//   addr_lo  : byte offset within the word (addr[1:0])
//   size     : SZ_BYTE / SZ_HALF / SZ_WORD
//   merged   : old_word with the addressed lane(s) replaced
module store_lane_merge
  import mips_mem_pkg::*;
#(
  parameter bit BIG_ENDIAN = BIG_ENDIAN_DEFAULT
) (
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  output logic [31:0] merged
);

  logic [1:0] byte_lane;
  logic       half_lane;

  always_comb begin
    // Big-endian byte 0 is the most significant lane: 3 - addr_lo == ~addr_lo.
    byte_lane = BIG_ENDIAN ? ~addr_lo    : addr_lo;
    half_lane = BIG_ENDIAN ? ~addr_lo[1] : addr_lo[1];
    merged    = old_word;
    case (size)
      SZ_BYTE: merged[{byte_lane, 3'b000} +: 8]  = wdata[7:0];
      SZ_HALF: merged[{half_lane, 4'b0000} +: 16] = wdata[15:0];
      SZ_WORD: merged = wdata;
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/store_merge_unit.sv
// Store unit performing byte/half stores as read-modify-write and word
// stores as a single write.
//   clk, rst          : clock, asynchronous active-high reset
//   req, size, addr,  : store request (sampled only when idle)
//   wdata
//   busy, done, fault : status; fault accompanies done on a rejected store
//   mem_*             : single-port memory handshake (mem_rdy acknowledges)
module store_merge_unit
  import mips_mem_pkg::*;
#(
  parameter bit BIG_ENDIAN = BIG_ENDIAN_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic        mem_rdy
);

  state_t      state_q, state_d;
  logic [31:0] addr_q,  addr_d;
  logic [1:0]  size_q,  size_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic [31:0] merged;

  store_lane_merge #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_merge (
    .old_word(rdata_q),
    .wdata   (wdata_q),
    .addr_lo (addr_q[1:0]),
    .size    (size_q),
    .merged  (merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = addr;
          size_d  = size;
          wdata_d = wdata;
          fault_d = store_faults(size, addr[1:0]);
          if (store_faults(size, addr[1:0])) state_d = ST_DONE;
          else if (size == SZ_WORD)          state_d = ST_WR;
          else                               state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (mem_rdy) begin
          rdata_d = mem_rdata;
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        if (mem_rdy) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode directly from registered state, so reset clears them
  // in the same cycle and the strobes are mutually exclusive by construction.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    fault     = (state_q == ST_DONE) && fault_q;
    mem_rd    = (state_q == ST_RD);
    mem_we    = (state_q == ST_WR);
    mem_addr  = {addr_q[31:2], 2'b00};
    mem_wdata = (state_q == ST_WR) ? merged : '0;
  end

endmodule

// File: tb/tb_store_merge_unit.sv
module tb_store_merge_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy, done, fault;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        mem_rdy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  store_merge_unit #(.BIG_ENDIAN(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .size     (size),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .fault    (fault),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_rdata(mem_rdata),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdy  (mem_rdy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Drives one request starting now; cycle 0 ends at the next rising edge.
  // Observes 14 cycles at the falling edge. rd_wait = extra RD cycles with
  // mem_rdy low; pulse = fire a second request while busy and scramble inputs.
  task automatic run_txn(
    input  logic [1:0]  sz,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [31:0] rd,
    input  int          rd_wait,
    input  bit          pulse,
    input  logic [31:0] exp_wdata,
    output int          done_cyc,
    output int          done_cnt,
    output bit          fault_at_done,
    output bit          rd_seen,
    output bit          we_seen,
    output bit          addr_bad,
    output bit          wdata_bad,
    output bit          both_high
  );
    int rd_cnt = 0;
    logic [31:0] exp_addr;
    exp_addr = {a[31:2], 2'b00};
    done_cyc = -1; done_cnt = 0; fault_at_done = 0;
    rd_seen = 0; we_seen = 0; addr_bad = 0; wdata_bad = 0; both_high = 0;
    size = sz; addr = a; wdata = wd; mem_rdata = rd;
    mem_rdy = (rd_wait == 0);
    req = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      req = 1'b0;
      if (pulse && c == 2) begin
        req = 1'b1; size = 2'b10; addr = 32'hFFFF_FFF0; wdata = 32'h0BAD_0BAD;
      end
      @(negedge clk);
      if (mem_rd) begin
        rd_seen = 1;
        rd_cnt++;
        if (mem_addr !== exp_addr) addr_bad = 1;
        mem_rdy = (rd_cnt > rd_wait);
      end
      if (mem_we) begin
        we_seen = 1;
        if (mem_addr !== exp_addr) addr_bad = 1;
        if (mem_wdata !== exp_wdata) wdata_bad = 1;
      end
      if (mem_rd && mem_we) both_high = 1;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c;
          fault_at_done = fault;
        end
      end
    end
    mem_rdy = 1'b1;
  endtask

  int dc, dn;
  bit ft, rs, ws, ab, wb, bh;

  initial begin
    rst = 1'b1; req = 0; size = 0; addr = 0; wdata = 0; mem_rdata = 0; mem_rdy = 1'b1;
    #12;
    check_eq("reset_outputs",
             {busy, done, fault, mem_rd, mem_we, (mem_addr != 0), (mem_wdata != 0)}, '0);
    @(negedge clk);
    rst = 1'b0;

    // Byte store, big-endian lane 2; request issued right after reset release.
    run_txn(2'b00, 32'h0000_1001, 32'hFFFF_FFAB, 32'h1122_3344, 0, 0, 32'h11AB_3344,
            dc, dn, ft, rs, ws, ab, wb, bh);
    check_eq("sb_done_cycle", dc, 3);
    check_eq("sb_done_count", dn, 1);
    check_eq("sb_fault", ft, 0);
    check_eq("sb_wdata", wb, 0);
    check_eq("sb_rd_seen", rs, 1);

    // Byte store to lane 0.
    run_txn(2'b00, 32'h0000_1003, 32'h0000_0055, 32'h1122_3344, 0, 0, 32'h1122_3355,
            dc, dn, ft, rs, ws, ab, wb, bh);
    check_eq("sb_lane0_wdata", wb, 0);
    check_eq("sb_lane0_done", dc, 3);

    // Half store at offset 2 -> low half in big-endian.
    run_txn(2'b01, 32'h0000_2002, 32'h0000_BEEF, 32'hAAAA_AAAA, 0, 0, 32'hAAAA_BEEF,
            dc, dn, ft, rs, ws, ab, wb, bh);
    check_eq("sh_wdata", wb, 0);
    check_eq("sh_addr_stable", ab, 0);
    check_eq("sh_done_cycle", dc, 3);

    // Half store at offset 0 -> high half; upper wdata bits ignored.
    run_txn(2'b01, 32'h0000_2000, 32'hFFFF_1234, 32'hCAFE_F00D, 0, 0, 32'h1234_F00D,
            dc, dn, ft, rs, ws, ab, wb, bh);
    check_eq("sh_hi_wdata", wb, 0);

    // Word store: no read, two-cycle latency.
    run_txn(2'b10, 32'h0000_3004, 32'hDEAD_BEEF, 32'h5555_5555, 0, 0, 32'hDEAD_BEEF,
            dc, dn, ft, rs, ws, ab, wb, bh);
    check_eq("sw_no_read", rs, 0);
    check_eq("sw_wdata", wb, 0);
    check_eq("sw_we_seen", ws, 1);
    check_eq("sw_done_cycle", dc, 2);

    // Misaligned half.
    run_txn(2'b01, 32'h0000_4001, 32'h0000_1111, 32'h0, 0, 0, 32'h0,
            dc, dn, ft, rs, ws, ab, wb, bh);
    check_eq("sh_mis_done_cycle", dc, 1);
    check_eq("sh_mis_fault", ft, 1);
    check_eq("sh_mis_no_access", {rs, ws}, 2'b00);

    // Illegal size.
    run_txn(2'b11, 32'h0000_0000, 32'h0000_2222, 32'h0, 0, 0, 32'h0,
            dc, dn, ft, rs, ws, ab, wb, bh);
    check_eq("sz11_done_cycle", dc, 1);
    check_eq("sz11_fault", ft, 1);
    check_eq("sz11_no_access", {rs, ws}, 2'b00);

    // Misaligned word.
    run_txn(2'b10, 32'h0000_3002, 32'h0000_3333, 32'h0, 0, 0, 32'h0,
            dc, dn, ft, rs, ws, ab, wb, bh);
    check_eq("sw_mis_fault", {ft, ws}, 2'b10);

    // Slow read plus a second request while busy with scrambled inputs.
    run_txn(2'b00, 32'h0000_5000, 32'h0000_0077, 32'h0000_0000, 5, 1, 32'h7700_0000,
            dc, dn, ft, rs, ws, ab, wb, bh);
    check_eq("stall_done_cycle", dc, 8);
    check_eq("stall_done_count", dn, 1);
    check_eq("stall_addr_stable", ab, 0);
    check_eq("stall_wdata_stable", wb, 0);
    check_eq("stall_exclusive", bh, 0);
    req = 1'b0;

    // Reset in the middle of a stalled write.
    mem_rdy = 1'b0;
    size = 2'b10; addr = 32'h0000_6000; wdata = 32'h1234_5678; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    check_eq("rst_pre_we", mem_we, 1);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_wr_outputs",
             {busy, done, fault, mem_rd, mem_we, (mem_addr != 0), (mem_wdata != 0)}, '0);
    dn = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check_eq("rst_no_done", dn, 0);
    mem_rdy = 1'b1;
    rst = 1'b0;
    run_txn(2'b00, 32'h0000_7002, 32'h0000_00C3, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_C3FF,
            dc, dn, ft, rs, ws, ab, wb, bh);
    check_eq("post_rst_done_cycle", dc, 3);
    check_eq("post_rst_wdata", wb, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_merge_unit.md
STORE_MERGE_UNIT -- requirements
Module: store_merge_unit

Interface
REQ-001 SHALL have parameter BIG_ENDIAN, default 1, selecting MIPS big-endian lane numbering (0 = little-endian).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req  input  1  store request, sampled only in IDLE.
REQ-005 SHALL have port size  input  2  00 byte (SB), 01 half (SH), 10 word (SW), 11 illegal.
REQ-006 SHALL have port addr  input  32  byte address of the store.
REQ-007 SHALL have port wdata  input  32  register value; only the low 8/16/32 bits are stored.
REQ-008 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port fault  output  1  high together with done when the request was misaligned or illegal.
REQ-011 SHALL have port mem_addr  output  32  word address {addr[31:2],2'b00}.
REQ-012 SHALL have port mem_rd  output  1  memory read strobe.
REQ-013 SHALL have port mem_rdata  input  32  memory read data, valid with mem_rdy during a read.
REQ-014 SHALL have port mem_we  output  1  memory write strobe.
REQ-015 SHALL have port mem_wdata  output  32  merged write word.
REQ-016 SHALL have port mem_rdy  input  1  memory acknowledge for the current mem_rd/mem_we.

Function
REQ-017 SHALL implement states IDLE, RD, WR, DONE.
REQ-018 In IDLE with req=1: SHALL capture addr, size and wdata, then transition as follows.
- Illegal or misaligned request: go to DONE, with no memory access.
- Word: go to WR.
- Byte or half: go to RD.
REQ-019 Misaligned SHALL mean half with addr[0]=1, or word with addr[1:0]!=0; size=11 is always illegal.
REQ-020 RD: SHALL hold mem_rd=1 and mem_addr stable until mem_rdy=1, then capture mem_rdata and go to WR.
REQ-021 WR: SHALL hold mem_we=1, mem_addr and mem_wdata stable until mem_rdy=1, then go to DONE.
REQ-022 DONE: SHALL assert done for exactly one cycle (fault per REQ-010), then return to IDLE.
REQ-023 Byte lane k = BIG_ENDIAN ? 3-addr[1:0] : addr[1:0]; wdata[7:0] SHALL replace bits [8k+7:8k] of the read word, and all other bits SHALL be preserved.
REQ-024 Half lane h = BIG_ENDIAN ? ~addr[1] : addr[1]; wdata[15:0] SHALL replace bits [16h+15:16h], and the other half SHALL be preserved.
REQ-025 Word: mem_wdata SHALL equal the captured wdata; no read is issued.
REQ-026 Upper unused bits of wdata (truncation) SHALL be ignored.
REQ-027 req while busy=1 SHALL be ignored, neither queued nor faulted.
REQ-028 mem_rdy outside RD/WR SHALL be ignored.
REQ-029 mem_rd and mem_we SHALL never be high in the same cycle.
REQ-030 Latency with mem_rdy tied high (req at cycle 0): word done at cycle 2; byte/half done at cycle 3; fault done at cycle 1.
REQ-031 Captured request registers SHALL NOT change while busy=1, even if the inputs change.

Reset
REQ-032 rst=1 SHALL immediately force IDLE and clear busy, done, fault, mem_rd, mem_we, mem_addr and mem_wdata to 0.
REQ-033 Reset mid-RD or mid-WR SHALL abandon the transaction with no done pulse; a write strobe already issued is not retracted.
REQ-034 The first req SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-035 A shared package/header mips_mem_pkg SHALL hold:
- size encodings (SZ_BYTE, SZ_HALF, SZ_WORD);
- FSM state constants;
- the BIG_ENDIAN default.
REQ-036 Lane insertion SHALL be a combinational sub-module store_lane_merge (inputs: old word, wdata, addr[1:0], size; output: merged word), instantiated once.

Verification
REQ-037 SB: addr=0x1001, wdata=0xFFFFFFAB, mem_rdata=0x11223344, BIG_ENDIAN=1 -> mem_wdata=0x11AB3344, done at cycle 3, fault=0.
REQ-038 SH: addr=0x2002, wdata=0x0000BEEF, mem_rdata=0xAAAAAAAA, BIG_ENDIAN=1 -> mem_wdata=0xAAAABEEF, and mem_addr=0x2000 throughout.
REQ-039 SW: addr=0x3004, wdata=0xDEADBEEF -> mem_rd never asserted, mem_wdata=0xDEADBEEF, done at cycle 2.
REQ-040 SH at addr=0x4001, and size=11 -> done and fault at cycle 1; mem_rd=mem_we=0 throughout.
REQ-041 mem_rdy held low 5 cycles in RD, and a second req pulsed while busy -> strobes held stable, single done pulse, second req dropped.
REQ-042 rst asserted during WR -> all outputs 0 in the same cycle, no done pulse, and the next req completes normally.
